display_scan_decoder: RTL and testbench

- Reads back a multiplexed 3-digit 7-segment display bus: active-low segment lines plus an active-low digit select.
- Decodes each segment code back to BCD and rebuilds the displayed decimal value, 0-999.
- Sits on the display pins alongside the counter/display driver, as the readback (decoder) end of that interface.
- Used for self-check, and for feeding the displayed value to other logic.

---
 rtl/display_scan_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_display_scan_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_decoder.sv
// display_scan_decoder: readback end of a multiplexed 3-digit 7-segment bus.
// Synchronizes the active-low segment/select pins, waits for each digit select
// to settle, decodes the segment code to BCD and assembles complete frames
// into {hundreds,tens,units} BCD and a binary value 0-999.
// Optional macro DISP_STABLE_FILTER_EN: outputs only follow a frame after it
// has repeated STABLE_FRAMES times in a row (error-free frames only).
module display_scan_decoder #(
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  sel_in,
    output logic [11:0] digits_out,
    output logic [9:0]  value_out,
    output logic        value_valid,
    output logic        frame_strobe,
    output logic        code_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    localparam logic [3:0] SEL_U = 4'b1110;
    localparam logic [3:0] SEL_T = 4'b1101;
    localparam logic [3:0] SEL_H = 4'b1011;

    // Decimal point is never decoded.
    logic dp_unused;
    assign dp_unused = seg_in[7];

    logic [6:0] seg_s1_q, s_seg;
    logic [3:0] sel_s1_q, s_sel;

    state_t          state_q;
    logic [3:0]      cur_sel_q;
    logic [7:0]      cnt_q;
    logic [2:0][3:0] dig_q, dig_d;
    logic [2:0]      seen_q, seen_d, err_q, err_d;
    logic [11:0]     digits_q;
    logic [9:0]      value_q, value_d;
    logic            valid_q, strobe_q, cerr_q;
    logic            frame_done, frame_err, upd;
    logic [4:0]      dec;

    // {err, bcd}: unknown codes decode to F with the error bit set.
    function automatic logic [4:0] seg_decode(input logic [6:0] c);
        case (c)
            7'h40:   seg_decode = 5'h00;
            7'h79:   seg_decode = 5'h01;
            7'h24:   seg_decode = 5'h02;
            7'h30:   seg_decode = 5'h03;
            7'h19:   seg_decode = 5'h04;
            7'h12:   seg_decode = 5'h05;
            7'h02:   seg_decode = 5'h06;
            7'h78:   seg_decode = 5'h07;
            7'h00:   seg_decode = 5'h08;
            7'h10:   seg_decode = 5'h09;
            default: seg_decode = 5'h1F;
        endcase
    endfunction

    function automatic logic sel_ok(input logic [3:0] s);
        sel_ok = (s == SEL_U) || (s == SEL_T) || (s == SEL_H);
    endfunction

    // Two-flop synchronizers on the asynchronous display pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1_q <= '1;
            s_seg    <= '1;
            sel_s1_q <= '1;
            s_sel    <= '1;
        end else begin
            seg_s1_q <= seg_in[6:0];
            s_seg    <= seg_s1_q;
            sel_s1_q <= sel_in;
            s_sel    <= sel_s1_q;
        end
    end

    // Slot write on capture; a frame completes on the capture that fills the last slot.
    always_comb begin
        dec    = seg_decode(s_seg);
        dig_d  = dig_q;
        seen_d = seen_q;
        err_d  = err_q;
        if (state_q == CAPTURE) begin
            case (cur_sel_q)
                SEL_U:   begin dig_d[0] = dec[3:0]; seen_d[0] = 1'b1; err_d[0] = dec[4]; end
                SEL_T:   begin dig_d[1] = dec[3:0]; seen_d[1] = 1'b1; err_d[1] = dec[4]; end
                SEL_H:   begin dig_d[2] = dec[3:0]; seen_d[2] = 1'b1; err_d[2] = dec[4]; end
                default: ;
            endcase
        end
        frame_done = (state_q == CAPTURE) && (&seen_d);
        frame_err  = |err_d;
        value_d    = {6'd0, dig_d[2]} * 10'd100 + {6'd0, dig_d[1]} * 10'd10 + {6'd0, dig_d[0]};
    end

`ifdef DISP_STABLE_FILTER_EN
    logic [2:0]  match_q, match_d;
    logic [11:0] prev_q;

    // Count consecutive identical error-free frames; publish once the run is long enough.
    always_comb begin
        match_d = match_q;
        upd     = 1'b0;
        if (frame_done) begin
            if (frame_err) begin
                match_d = 3'd0;
            end else begin
                if (dig_d == prev_q) begin
                    if (match_q < 3'(STABLE_FRAMES)) match_d = match_q + 3'd1;
                end else begin
                    match_d = 3'd1;
                end
                upd = (match_d == 3'(STABLE_FRAMES));
            end
        end
    end

    // Run-length state for the stability filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q <= '0;
            prev_q  <= '0;
        end else begin
            match_q <= match_d;
            if (frame_done && !frame_err) prev_q <= dig_d;
        end
    end
`else
    logic [2:0] stable_unused;
    assign stable_unused = 3'(STABLE_FRAMES);

    // Every error-free frame is published immediately.
    always_comb upd = frame_done && !frame_err;
`endif

    // Scan FSM plus slot/flag bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_sel_q <= '1;
            cnt_q     <= '0;
            dig_q     <= '0;
            seen_q    <= '0;
            err_q     <= '0;
            digits_q  <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            cerr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (sel_ok(s_sel)) begin
                    state_q   <= SETTLE;
                    cur_sel_q <= s_sel;
                    cnt_q     <= '0;
                end
                SETTLE: begin
                    if (s_sel != cur_sel_q) begin
                        if (sel_ok(s_sel)) begin
                            cur_sel_q <= s_sel;
                            cnt_q     <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                CAPTURE: state_q <= HOLD;
                HOLD: if (s_sel != cur_sel_q) begin
                    if (sel_ok(s_sel)) begin
                        state_q   <= SETTLE;
                        cur_sel_q <= s_sel;
                        cnt_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            dig_q    <= dig_d;
            seen_q   <= frame_done ? 3'b000 : seen_d;
            err_q    <= frame_done ? 3'b000 : err_d;
            strobe_q <= frame_done;
            cerr_q   <= frame_done && frame_err;
            if (upd) begin
                digits_q <= dig_d;
                value_q  <= value_d;
                valid_q  <= 1'b1;
            end
        end
    end

    assign digits_out   = digits_q;
    assign value_out    = value_q;
    assign value_valid  = valid_q;
    assign frame_strobe = strobe_q;
    assign code_err     = cerr_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: drives full/partial scans on the
// display pins and checks frame results against hand-computed values.
module tb_display_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  sel_in = 4'hF;
    logic [11:0] digits_out;
    logic [9:0]  value_out;
    logic        value_valid, frame_strobe, code_err;

    int errors = 0;
    int checks = 0;
    int n_strobe = 0;
    int n_cerr = 0;
    int n_orphan = 0;

    display_scan_decoder #(.SETTLE_CYCLES(16), .STABLE_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in),
        .digits_out(digits_out), .value_out(value_out), .value_valid(value_valid),
        .frame_strobe(frame_strobe), .code_err(code_err)
    );

    always #10 clk = ~clk;

    // Tally pulses just after each edge.
    always @(posedge clk) begin
        #1;
        if (frame_strobe) n_strobe++;
        if (code_err) n_cerr++;
        if (code_err && !frame_strobe) n_orphan++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [6:0] segof(input int d);
        case (d)
            0: segof = 7'h40;  1: segof = 7'h79;  2: segof = 7'h24;  3: segof = 7'h30;
            4: segof = 7'h19;  5: segof = 7'h12;  6: segof = 7'h02;  7: segof = 7'h78;
            8: segof = 7'h00;  9: segof = 7'h10;  default: segof = 7'h7F;
        endcase
    endfunction

    task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
        @(negedge clk);
        sel_in = sel;
        seg_in = {1'b1, seg};
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        show(4'b1110, u, 64);
        show(4'b1101, t, 64);
        show(4'b1011, h, 64);
        show(4'b1111, 7'h7F, 64);
    endtask

    task automatic scan_dec(input int h, input int t, input int u);
        scan(segof(h), segof(t), segof(u));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    int s0, e0;

    initial begin
        // Reset held with random pin activity.
        repeat (20) begin
            @(negedge clk);
            seg_in = 8'($urandom);
            sel_in = 4'($urandom);
        end
        chk("rst_digits", int'(digits_out), 0);
        chk("rst_value", int'(value_out), 0);
        chk("rst_valid", int'(value_valid), 0);
        chk("rst_strobe", int'(frame_strobe), 0);
        chk("rst_cerr", int'(code_err), 0);
        @(negedge clk);
        seg_in = 8'hFF;
        sel_in = 4'hF;
        rst = 1'b1;

`ifdef DISP_STABLE_FILTER_EN
        s0 = n_strobe;
        scan_dec(2, 0, 0);
        chk("flt_200_value", int'(value_out), 0);
        chk("flt_200_valid", int'(value_valid), 0);
        scan_dec(2, 0, 1);
        chk("flt_201a_value", int'(value_out), 0);
        chk("flt_201a_valid", int'(value_valid), 0);
        scan_dec(2, 0, 1);
        chk("flt_201b_value", int'(value_out), 201);
        chk("flt_201b_digits", int'(digits_out), 'h201);
        chk("flt_201b_valid", int'(value_valid), 1);
        chk("flt_strobes", n_strobe - s0, 3);
        chk("flt_cerr", n_cerr, 0);
`else
        // Only two digits after reset: no frame yet.
        s0 = n_strobe;
        show(4'b1110, segof(9), 64);
        show(4'b1101, segof(9), 64);
        show(4'b1111, 7'h7F, 64);
        chk("partial_no_strobe", n_strobe - s0, 0);

        // Scan 123.
        s0 = n_strobe; e0 = n_cerr;
        scan_dec(1, 2, 3);
        chk("s123_strobe", n_strobe - s0, 1);
        chk("s123_digits", int'(digits_out), 'h123);
        chk("s123_value", int'(value_out), 123);
        chk("s123_valid", int'(value_valid), 1);
        chk("s123_cerr", n_cerr - e0, 0);

        // 255 with a bad units code: rejected, previous value held.
        s0 = n_strobe; e0 = n_cerr;
        scan(segof(2), segof(5), 7'h7F);
        chk("bad_strobe", n_strobe - s0, 1);
        chk("bad_cerr", n_cerr - e0, 1);
        chk("bad_orphan_cerr", n_orphan, 0);
        chk("bad_value_held", int'(value_out), 123);
        chk("bad_digits_held", int'(digits_out), 'h123);

        // Tens dwell shorter than the settle window is ignored.
        s0 = n_strobe;
        show(4'b1110, segof(2), 64);
        show(4'b1101, segof(4), 10);
        show(4'b1011, segof(0), 64);
        show(4'b1111, 7'h7F, 64);
        chk("glitch_no_strobe", n_strobe - s0, 0);
        s0 = n_strobe;
        scan_dec(0, 4, 2);
        chk("s042_strobe", n_strobe - s0, 1);
        chk("s042_value", int'(value_out), 42);
        chk("s042_digits", int'(digits_out), 'h042);

        // Reset after units+tens discards them.
        show(4'b1110, segof(7), 64);
        show(4'b1101, segof(0), 64);
        reset_pulse();
        chk("mid_rst_value", int'(value_out), 0);
        chk("mid_rst_digits", int'(digits_out), 0);
        chk("mid_rst_valid", int'(value_valid), 0);
        s0 = n_strobe;
        show(4'b1011, segof(0), 64);
        show(4'b1111, 7'h7F, 64);
        chk("mid_rst_no_strobe", n_strobe - s0, 0);
        s0 = n_strobe;
        scan_dec(0, 0, 7);
        chk("s007_strobe", n_strobe - s0, 1);
        chk("s007_value", int'(value_out), 7);
        chk("s007_valid", int'(value_valid), 1);

        // Upper bound and blank-phase / 4th-select immunity.
        reset_pulse();
        show(4'b1110, segof(9), 64);
        show(4'b0111, segof(1), 64);
        show(4'b1111, 7'h7F, 64);
        show(4'b1101, segof(9), 64);
        s0 = n_strobe;
        show(4'b1011, segof(9), 64);
        show(4'b1111, 7'h7F, 64);
        chk("s999_strobe", n_strobe - s0, 1);
        chk("s999_value", int'(value_out), 999);
        chk("s999_digits", int'(digits_out), 'h999);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
